onchip_memory_streamer: RTL

Avalon-MM master that drives the single-port on-chip memory (32-bit words, 14-bit word address, 9600 words, fixed 1-cycle read latency, no waitrequest). On a `start` command it reads a contiguous, wrap-around range of words and presents them on a ready/valid stream with a last-word marker. It sits between the on-chip memory's s2 port and downstream consumers such as pixel or DMA logic, and frees the Nios core from copy loops.

---
 rtl/onchip_memory_streamer_pkg.sv | 16 +
 rtl/onchip_memory_streamer_if.sv | 31 +++
 rtl/onchip_memory_streamer_stream_fifo.sv | 46 ++++
 rtl/onchip_memory_streamer.sv | 122 ++++++++++++
 4 files changed

// File: rtl/onchip_memory_streamer_pkg.sv
// Shared types and defaults for the on-chip memory streamer.
// ONCHIP_STREAM_FILL_EN (optional) adds a constant-fill write mode to the top.
package onchip_stream_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 9600;
  localparam int RD_LAT     = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/onchip_memory_streamer_if.sv
// Memory-side Avalon-MM bus plus output stream of the streamer.
interface onchip_memory_streamer_if
  import onchip_stream_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                clken;
  logic [DATA_W-1:0]   readdata;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    output out_data, out_valid, out_last,
    input  readdata, out_ready
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    input  out_data, out_valid, out_last,
    output readdata, out_ready
  );
endinterface

// File: rtl/onchip_memory_streamer_stream_fifo.sv
// Small synchronous FIFO carrying data plus a last flag; output comes straight
// from the storage registers so it holds steady while the consumer stalls.
module stream_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   push_last,
  input  logic                   pop,
  output logic [W-1:0]           out_data,
  output logic                   out_last,
  output logic                   out_valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_pop;

  assign do_pop    = pop && (count != '0);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr][W-1:0];
  assign out_last  = out_valid & mem[rd_ptr][W];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_last, push_data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end
endmodule

// File: rtl/onchip_memory_streamer.sv
// Reads a wrap-around range of on-chip memory words onto a ready/valid stream.
// ONCHIP_STREAM_FILL_EN adds fill_mode/fill_data for a constant-fill write pass.
module onchip_memory_streamer
  import onchip_stream_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
`ifdef ONCHIP_STREAM_FILL_EN
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_data,
`endif
  onchip_memory_streamer_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_q, remain_q;
  logic              done_q, fill_q;
  logic              rd_issue, wr_issue, room, pop, last_issue, accept;
  logic [RD_LAT-1:0] vld_pipe, last_pipe;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_last, fifo_valid;
  logic [CNT_W-1:0]  fifo_count;

  assign accept     = (state == IDLE) && start;
  assign last_issue = (remain_q == ADDR_W'(1));
  // Count the read already on the bus so its data always has a slot to land in.
  assign room       = (int'(fifo_count) + int'(|vld_pipe)) < FIFO_DEPTH;
  assign pop        = fifo_valid & bus.out_ready;

  always_comb begin
    state_d  = state;
    rd_issue = 1'b0;
    wr_issue = 1'b0;
    unique case (state)
      IDLE:  if (start && length != '0) state_d = RUN;
      RUN: begin
        wr_issue = fill_q;
        rd_issue = !fill_q && room;
        if ((wr_issue || rd_issue) && last_issue) state_d = DRAIN;
      end
      DRAIN: if (fill_q || (pop && fifo_last)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      done_q    <= 1'b0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      state     <= state_d;
      done_q    <= accept && (length == '0);
      vld_pipe  <= (vld_pipe << 1) | RD_LAT'(rd_issue);
      last_pipe <= (last_pipe << 1) | RD_LAT'(rd_issue && last_issue);
      if (accept) begin
        addr_q   <= base_addr;
        remain_q <= length;
      end else if (rd_issue || wr_issue) begin
        addr_q   <= (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
        remain_q <= remain_q - 1'b1;
      end
    end
  end

`ifdef ONCHIP_STREAM_FILL_EN
  logic [DATA_W-1:0] fill_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else if (accept) begin
      fill_q      <= fill_mode;
      fill_data_q <= fill_data;
    end
  end

  assign bus.writedata = fill_data_q;
`else
  assign fill_q        = 1'b0;
  assign bus.writedata = '0;
`endif

  stream_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (vld_pipe[RD_LAT-1]),
    .push_data (bus.readdata),
    .push_last (last_pipe[RD_LAT-1]),
    .pop       (pop),
    .out_data  (fifo_data),
    .out_last  (fifo_last),
    .out_valid (fifo_valid),
    .count     (fifo_count)
  );

  assign bus.chipselect = rd_issue | wr_issue;
  assign bus.write      = wr_issue;
  assign bus.address    = addr_q;
  assign bus.byteenable = {(DATA_W/8){bus.chipselect}};
  assign bus.clken      = reset_n;
  assign bus.out_data   = fifo_data;
  assign bus.out_valid  = fifo_valid;
  assign bus.out_last   = fifo_last;
  assign busy           = (state != IDLE);
  assign done           = done_q | ((state == DRAIN) && (fill_q || (pop && fifo_last)));
endmodule
